// File: rtl/ram_64x8.sv
// rtl/ram_64x8.sv - 64x8 single-port RAM with registered read and reset-loaded image
// Reset reloads every word with a*4 and clears dout; reads are read-first, one-cycle latency.
module ram_64x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is held as registers so the whole image can be restored by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= DATA_W'(a * 4);
      end
    end else begin
      if (wr) begin
        mem[address] <= din;
      end
      dout <= mem[address];
    end
  end

endmodule

// File: tb/tb_ram_64x8.sv
// tb/tb_ram_64x8.sv - self-checking bench for ram_64x8
// A word-array model tracks contents and expected dout; a negedge process compares every cycle.
module tb_ram_64x8;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [5:0] address;
  logic [7:0] din;
  logic [7:0] dout;

  int tests = 0;
  int fails = 0;

  logic [7:0] model [64];
  logic [7:0] exp_dout;
  bit         chk_en = 0;

  ram_64x8 #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .address (address),
    .din     (din),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (dout !== exp_dout) begin
        fails++;
        $display("FAIL cycle_compare t=%0t addr=%0d got=%02h want=%02h", $time, address, dout, exp_dout);
      end
    end
  end

  task automatic model_reset();
    for (int a = 0; a < 64; a++) model[a] = 8'((a * 4) % 256);
    exp_dout = 8'h00;
  endtask

  task automatic check(input string name, input logic [7:0] want);
    tests++;
    if (dout !== want) begin
      fails++;
      $display("FAIL %s got=%02h want=%02h", name, dout, want);
    end
  endtask

  // One clock of access; returns at posedge+1 with the model advanced.
  task automatic cycle(input logic w, input logic [5:0] a, input logic [7:0] d);
    wr = w;
    address = a;
    din = d;
    @(posedge clk);
    exp_dout = model[a];
    if (w) model[a] = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr = 1'b0;
    address = '0;
    din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    check("reset_dout_zero", 8'h00);
    rst_n = 1'b1;

    for (int a = 0; a < 64; a++) begin
      cycle(1'b0, 6'(a), 8'bx);
      check($sformatf("image_addr_%0d", a), 8'(a * 4));
    end
    check("image_addr_63_is_252", 8'd252);

    cycle(1'b1, 6'd10, 8'hA5);
    cycle(1'b1, 6'd63, 8'h3C);
    cycle(1'b0, 6'd10, 8'h00);
    check("readback_10", 8'hA5);
    cycle(1'b0, 6'd63, 8'h00);
    check("readback_63", 8'h3C);
    cycle(1'b0, 6'd11, 8'h00);
    check("untouched_11", 8'd44);

    cycle(1'b1, 6'd5, 8'hFF);
    check("read_first_old", 8'd20);
    cycle(1'b0, 6'd5, 8'h00);
    check("read_first_new", 8'hFF);

    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_dout", 8'h00);
    #4;
    rst_n = 1'b1;
    cycle(1'b0, 6'd10, 8'h00);
    check("image_restored_10", 8'd40);

    for (int a = 0; a < 64; a++) begin
      cycle(1'b1, 6'(a), 8'(~a));
      cycle(1'b0, 6'(a), 8'h00);
      check($sformatf("b2b_addr_%0d", a), 8'(~a));
    end

    wr = 1'b1;
    address = 6'd7;
    din = 8'h99;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_during_write_dout", 8'h00);
    rst_n = 1'b1;
    cycle(1'b0, 6'd7, 8'h00);
    check("reset_overrides_write_7", 8'd28);
    cycle(1'b0, 6'd7, 8'h00);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_64x8.md
RAM_64X8 -- requirements
Module: ram_64x8

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning number of words (2**ADDR_W).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge except reset.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port wr, input, 1 bit: write enable, active-high.
REQ-007 The block SHALL have port address, input, ADDR_W bits: word address for both read and write.
REQ-008 The block SHALL have port din, input, DATA_W bits: write data.
REQ-009 The block SHALL have port dout, output, DATA_W bits: registered read data.

Function
REQ-010 The storage SHALL be DEPTH words of DATA_W bits, addressed 0..DEPTH-1, organised logically as an 8x8 image in row-major order (address = row*8 + col).
REQ-011 On a rising clk edge with rst_n high and wr=1, the block SHALL write din into mem[address].
REQ-012 On every rising clk edge with rst_n high, the block SHALL load dout with mem[address], regardless of wr.
REQ-013 Read latency SHALL be exactly one clock: an address presented before edge N appears on dout after edge N.
REQ-014 Read-during-write to the same address SHALL be read-first: dout shows the old contents, and the new value is visible on the next read.
REQ-015 With wr=0 the memory contents SHALL be unchanged.
REQ-016 address SHALL be used unmodified; all 2**ADDR_W values are valid and there is no out-of-range case at the defaults.
REQ-017 There SHALL be no bypass, byte enables or second port; one access per cycle.

Reset
REQ-018 While rst_n=0, dout SHALL be 0, asynchronously and independent of clk.
REQ-019 While rst_n=0, every word SHALL be loaded with the default image mem[a] = a*4 mod 2**DATA_W (a = 0..63, giving 0,4,8,...,252).
REQ-020 rst_n deasserting SHALL have no effect until the next rising clk edge; the first edge with rst_n=1 behaves per REQ-011/012.
REQ-021 A reset asserted mid-operation, including in a cycle with wr=1, SHALL override the write; the image SHALL be restored and dout forced to 0.
REQ-022 X or Z on din while wr=0 SHALL NOT corrupt memory.

Verification
REQ-023 Reset then read: pulse rst_n low, then with wr=0 sweep address 0..63 -> dout is 0 during reset; one cycle after each address it shows address*4 (e.g. addr 63 -> 252).
REQ-024 Write/readback: write din=8'hA5 at address 10 and 8'h3C at address 63, then read both -> 8'hA5 and 8'h3C; address 11 still reads 44.
REQ-025 Read-first: wr=1, address=5, din=8'hFF in one cycle -> dout=20 after that edge; the next cycle with wr=0, address=5 -> dout=8'hFF.
REQ-026 Async reset: assert rst_n low between clock edges after writes -> dout goes 0 immediately with no clk edge; after release, address 10 reads 40 (image restored).
REQ-027 Back-to-back: alternate write and read on consecutive cycles across all 64 addresses with din=~address -> every readback matches, with 1-cycle latency and no stalls.
REQ-028 Reset during write: rst_n=0 coincident with wr=1, address=7, din=8'h99 -> after release, address 7 reads 28.
